// File: rtl/crack_dispatcher.sv
// Chunked work dispatcher for the SHA-256 password-cracking engines: hands out
// decimal candidate ranges round-robin, latches the first hit and times the search.
module crack_dispatcher #(
  parameter int NUM_WORKERS = 6,
  parameter int DIGITS      = 9,
  parameter int CHUNK_LOG10 = 5,
  parameter int TICK_CYCLES = 100_000_000,
  parameter int TIMER_W     = 56
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic [NUM_WORKERS-1:0]          req,
  input  logic [NUM_WORKERS-1:0]          w_idle,
  input  logic [NUM_WORKERS-1:0]          w_found,
  input  logic [NUM_WORKERS*8*DIGITS-1:0] w_value,
  output logic [NUM_WORKERS-1:0]          grant,
  output logic [8*DIGITS-1:0]             chunk_base,
  output logic                            kill,
  output logic                            busy,
  output logic                            found,
  output logic                            exhausted,
  output logic [8*DIGITS-1:0]             result,
  output logic [TIMER_W-1:0]              ticks
);

  localparam int RW = (NUM_WORKERS > 1) ? $clog2(NUM_WORKERS) : 1;
  localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int VW = 8 * DIGITS;
  localparam logic [VW-1:0] ZERO_BASE = {DIGITS{8'h30}};
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [VW-1:0]        next_base;
  logic [RW-1:0]        rr_ptr;
  logic [PW-1:0]        prescaler;

  logic [VW-1:0]        inc_base;
  logic                 inc_carry;
  logic                 carry;
  logic [NUM_WORKERS-1:0] req_eff;
  logic [NUM_WORKERS-1:0] pick_oh;
  logic                 pick_valid;
  logic [RW-1:0]        rr_next;
  int                   idx;
  logic                 found_any;
  logic [VW-1:0]        found_val;

  // Decimal ripple increment at character CHUNK_LOG10; low characters stay '0'.
  // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    inc_base = next_base;
    carry    = 1'b1;
    for (int k = CHUNK_LOG10; k < DIGITS; k++) begin
      if (carry) begin
        if (next_base[8*k +: 8] == 8'h39) begin
          inc_base[8*k +: 8] = 8'h30;
        end else begin
          inc_base[8*k +: 8] = next_base[8*k +: 8] + 8'd1;
          carry = 1'b0;
        end
      end
    end
    inc_carry = carry;
  end

  // Round-robin pick from rr_ptr upward; a worker just granted is blanked one cycle.
  always_comb begin
    req_eff    = req & ~grant;
    pick_oh    = '0;
    pick_valid = 1'b0;
    rr_next    = rr_ptr;
    idx        = 0;
    for (int off = 0; off < NUM_WORKERS; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= NUM_WORKERS) idx = idx - NUM_WORKERS;
      if (!pick_valid && req_eff[idx]) begin
        pick_valid   = 1'b1;
        pick_oh[idx] = 1'b1;
        rr_next      = RW'((idx + 1) % NUM_WORKERS);
      end
    end
  end

  // Lowest-index finder wins: scan downward so the last assignment is the lowest.
  always_comb begin
    found_any = |w_found;
    found_val = '0;
    for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
      if (w_found[i]) found_val = w_value[i*VW +: VW];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= IDLE;
      next_base  <= ZERO_BASE;
      rr_ptr     <= '0;
      prescaler  <= '0;
      grant      <= '0;
      chunk_base <= ZERO_BASE;
      kill       <= 1'b0;
      busy       <= 1'b0;
      found      <= 1'b0;
      exhausted  <= 1'b0;
      result     <= ZERO_BASE;
      ticks      <= '0;
    end else begin
      grant <= '0;
      kill  <= 1'b0;

      if (state == RUN || state == DRAIN) begin
        if (prescaler == PRESC_LAST) begin
          prescaler <= '0;
          if (ticks != '1) ticks <= ticks + 1'b1;
        end else begin
          prescaler <= prescaler + 1'b1;
        end
      end

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state     <= RUN;
            busy      <= 1'b1;
            found     <= 1'b0;
            exhausted <= 1'b0;
            ticks     <= '0;
            prescaler <= '0;
            next_base <= ZERO_BASE;
            rr_ptr    <= '0;
          end
        end
        RUN, DRAIN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            kill  <= 1'b1;
          end else if (found_any) begin
            state  <= DONE;
            busy   <= 1'b0;
            found  <= 1'b1;
            result <= found_val;
            kill   <= 1'b1;
          end else if (state == RUN) begin
            if (pick_valid) begin
              grant      <= pick_oh;
              chunk_base <= next_base;
              next_base  <= inc_base;
              rr_ptr     <= rr_next;
              if (inc_carry) state <= DRAIN;
            end
          end else if (&w_idle) begin
            state     <= DONE;
            busy      <= 1'b0;
            exhausted <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_crack_dispatcher.sv
// Directed bench for crack_dispatcher: 4 workers, 3 digits, chunks of 10,
// 4-cycle ticks and a 3-bit timer so saturation is reachable.
module tb_crack_dispatcher;

  localparam int N  = 4;
  localparam int D  = 3;
  localparam int VW = 8 * D;
  localparam logic [VW-1:0] ZERO_BASE = 24'h303030;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic            abort;
  logic [N-1:0]    req;
  logic [N-1:0]    w_idle;
  logic [N-1:0]    w_found;
  logic [N*VW-1:0] w_value;
  logic [N-1:0]    grant;
  logic [VW-1:0]   chunk_base;
  logic            kill;
  logic            busy;
  logic            found;
  logic            exhausted;
  logic [VW-1:0]   result;
  logic [2:0]      ticks;

  int checks   = 0;
  int failures = 0;

  crack_dispatcher #(
    .NUM_WORKERS(N), .DIGITS(D), .CHUNK_LOG10(1), .TICK_CYCLES(4), .TIMER_W(3)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .req(req),
    .w_idle(w_idle), .w_found(w_found), .w_value(w_value), .grant(grant),
    .chunk_base(chunk_base), .kill(kill), .busy(busy), .found(found),
    .exhausted(exhausted), .result(result), .ticks(ticks)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [VW-1:0] base_of(input int k);
    return {8'(48 + k / 10), 8'(48 + k % 10), 8'h30};
  endfunction

  initial begin
    int n;
    logic [N-1:0] seen;

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    req = '0; w_idle = '0; w_found = '0; w_value = '0;
    step(); step();
    check("rst_grant", grant, 0);
    check("rst_base", chunk_base, ZERO_BASE);
    check("rst_result", result, ZERO_BASE);
    check("rst_flags", {kill, busy, found, exhausted}, 0);
    check("rst_ticks", ticks, 0);
    reset_n = 1'b1;
    step();

    // Full sweep: 100 chunks alternating w0/w1, then drain to exhaustion.
    req = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", busy, 1);
    n = 0;
    for (int c = 0; c < 150 && n < 100; c++) begin
      step();
      if (grant != 0) begin
        check("t1_grant", grant, (n % 2 == 0) ? 4'b0001 : 4'b0010);
        check("t1_base", chunk_base, base_of(n));
        n++;
      end
    end
    check("t1_count", n, 100);
    step();
    check("t1_drain_grant", grant, 0);
    check("t1_drain_busy", busy, 1);
    check("t1_drain_exh", exhausted, 0);
    w_idle = 4'b1111;
    step();
    check("t1_exhausted", exhausted, 1);
    check("t1_found", found, 0);
    check("t1_busy_off", busy, 0);
    check("t1_ticks_sat", ticks, 7);
    step();
    check("t1_ticks_hold", ticks, 7);

    // Hit at the 13th grant: found, result latched, single kill pulse.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t2_cleared", {exhausted, found, ticks}, 0);
    n = 0;
    for (int c = 0; c < 30 && n < 13; c++) begin
      step();
      if (grant != 0) n++;
    end
    check("t2_count", n, 13);
    w_found = 4'b0010;
    w_value[1*VW +: VW] = 24'h313233;
    step();
    w_found = '0;
    check("t2_found", found, 1);
    check("t2_result", result, 24'h313233);
    check("t2_kill", kill, 1);
    check("t2_grant", grant, 0);
    check("t2_busy", busy, 0);
    seen = '0;
    step();
    check("t2_kill_off", kill, 0);
    seen |= grant;
    step();
    seen |= grant;
    check("t2_no_grants", seen, 0);

    // Simultaneous finders: lowest index wins.
    req = '0; start = 1'b1;
    step();
    start = 1'b0;
    w_found = 4'b0101;
    w_value[0*VW +: VW] = 24'h313131;
    w_value[1*VW +: VW] = 24'h353535;
    w_value[2*VW +: VW] = 24'h373737;
    step();
    w_found = '0;
    check("t3_result", result, 24'h313131);
    check("t3_found", {found, exhausted}, 2'b10);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t3_abort_ignored", {found, kill, busy}, 3'b100);

    // Abort after 5 grants with 21 busy cycles: ticks = 5 held.
    req = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_cleared", {found, ticks}, 0);
    n = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (grant != 0) n++;
      if (n == 5) req = '0;
    end
    check("t4_count", n, 5);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("t4_idle", {busy, found, exhausted}, 0);
    check("t4_kill", kill, 1);
    check("t4_ticks", ticks, 5);
    step();
    check("t4_kill_off", kill, 0);
    step();
    check("t4_ticks_hold", ticks, 5);
    req = 4'b0011; start = 1'b1;
    step();
    start = 1'b0;
    check("t4_restart_ticks", ticks, 0);
    check("t4_restart_busy", busy, 1);
    step();
    check("t4_restart_grant", grant, 4'b0001);
    check("t4_restart_base", chunk_base, ZERO_BASE);
    req = '0; abort = 1'b1;
    step();
    abort = 1'b0;
    step();

    // Lone requester w3: grants every other cycle; pointer wraps to 0.
    req = 4'b1000; start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_g1", grant, 4'b1000);
    check("t5_b1", chunk_base, base_of(0));
    step();
    check("t5_blank1", grant, 0);
    step();
    check("t5_g2", grant, 4'b1000);
    check("t5_b2", chunk_base, base_of(1));
    step();
    check("t5_blank2", grant, 0);
    step();
    check("t5_g3", grant, 4'b1000);
    req = 4'b0011;
    step();
    check("t5_wrap_w0", grant, 4'b0001);
    check("t5_wrap_base", chunk_base, base_of(3));
    step();
    check("t5_next_w1", grant, 4'b0010);

    // Reset mid-RUN dominates start and w_found.
    reset_n = 1'b0; start = 1'b1; w_found = 4'b1111;
    step();
    check("t6_grant", grant, 0);
    check("t6_flags", {kill, busy, found, exhausted}, 0);
    check("t6_base", chunk_base, ZERO_BASE);
    check("t6_result", result, ZERO_BASE);
    check("t6_ticks", ticks, 0);
    step();
    check("t6_hold", {busy, found}, 0);
    reset_n = 1'b1; start = 1'b0; w_found = '0;
    step();
    check("t6_after", {busy, grant}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
